// File: rtl/mvm_stream_core.sv
// mvm_stream_core: streaming matrix-vector multiply, Y = K * X.
// K is R x C and X has C elements. Operands arrive as bytes, K first and
// then X. The R results leave as words. If keep_k is high at the final
// output handshake, the stored K is reused and the next frame carries X only.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   s_data/s_valid/s_ready  input byte stream (element in the low bits)
//   m_data/m_valid/m_ready  output word stream (Y[0] .. Y[R-1])
//   keep_k               sampled on the last output handshake
//   busy                 high while computing or sending
//   done                 one-cycle pulse after the last output handshake
module mvm_stream_core #(
  parameter int R        = 2,
  parameter int C        = 2,
  parameter int W_X      = 4,
  parameter int W_K      = 4,
  parameter int W_Y_OUT  = 8,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [W_Y_OUT-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  input  logic               keep_k,
  output logic               busy,
  output logic               done
);

  localparam int RC    = R * C;
  localparam int W_ACC = W_X + W_K + $clog2(C) + 1;
  localparam int CW    = ((W_ACC > W_Y_OUT) ? W_ACC : W_Y_OUT) + 1;
  localparam int KW    = (RC > 1) ? $clog2(RC) : 1;
  localparam int XW    = (C > 1) ? $clog2(C) : 1;
  localparam int YW    = (R > 1) ? $clog2(R) : 1;

  localparam logic [KW-1:0] LAST_K = KW'(RC - 1);
  localparam logic [XW-1:0] LAST_C = XW'(C - 1);
  localparam logic [YW-1:0] LAST_R = YW'(R - 1);

  localparam logic signed [CW-1:0] MAX_S = CW'((1 << (W_Y_OUT - 1)) - 1);
  localparam logic signed [CW-1:0] MIN_S = CW'(-(1 << (W_Y_OUT - 1)));
  localparam logic signed [CW-1:0] MAX_U = CW'((1 << W_Y_OUT) - 1);

  typedef enum logic [1:0] {LOAD_K, LOAD_X, COMPUTE, SEND} state_t;

  state_t state, state_next;

  logic [W_K-1:0]     k_mem [RC];
  logic [W_X-1:0]     x_mem [C];
  logic [W_Y_OUT-1:0] y_mem [R];

  // idx: K write index while loading, flat MAC index while computing.
  // col: X write index while loading, MAC column while computing.
  // row: MAC row while computing, output index while sending.
  logic [KW-1:0]    idx;
  logic [XW-1:0]    col;
  logic [YW-1:0]    row;
  logic [W_ACC-1:0] acc, prod, sum;
  logic             k_valid;

  // Only the low element bits of each input byte carry data.
  logic unused_hi;
  assign unused_hi = ^s_data;

  function automatic logic [W_ACC-1:0] ext_k(input logic [W_K-1:0] v);
    if (SIGNED != 0) return {{(W_ACC - W_K){v[W_K-1]}}, v};
    return {{(W_ACC - W_K){1'b0}}, v};
  endfunction

  function automatic logic [W_ACC-1:0] ext_x(input logic [W_X-1:0] v);
    if (SIGNED != 0) return {{(W_ACC - W_X){v[W_X-1]}}, v};
    return {{(W_ACC - W_X){1'b0}}, v};
  endfunction

  // The accumulator is widened by one bit so that both the signed limits and
  // the unsigned limit can be compared in a single signed domain.
  function automatic logic [W_Y_OUT-1:0] conv(input logic [W_ACC-1:0] s);
    logic signed [CW-1:0] a;
    a = signed'({{(CW - W_ACC){s[W_ACC-1]}}, s});
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if (a > MAX_S) return MAX_S[W_Y_OUT-1:0];
        if (a < MIN_S) return MIN_S[W_Y_OUT-1:0];
      end else begin
        if (a > MAX_U) return MAX_U[W_Y_OUT-1:0];
      end
    end
    return a[W_Y_OUT-1:0];
  endfunction

  // Product is taken modulo 2^W_ACC; with sign-extended operands this equals
  // the exact signed product because the accumulator width never overflows.
  always_comb begin
    prod = ext_k(k_mem[idx]) * ext_x(x_mem[col]);
    sum  = ((col == '0) ? '0 : acc) + prod;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_K;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD_K:  if (s_valid && idx == LAST_K) state_next = LOAD_X;
      LOAD_X:  if (s_valid && col == LAST_C) state_next = COMPUTE;
      COMPUTE: if (idx == LAST_K) state_next = SEND;
      SEND:    if (m_ready && row == LAST_R)
                 state_next = (keep_k && k_valid) ? LOAD_X : LOAD_K;
      default: state_next = LOAD_K;
    endcase
  end

  always_comb begin
    s_ready = (state == LOAD_K) || (state == LOAD_X);
    m_valid = (state == SEND);
    busy    = (state == COMPUTE) || (state == SEND);
    m_data  = m_valid ? y_mem[row] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      col     <= '0;
      row     <= '0;
      acc     <= '0;
      k_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        LOAD_K: if (s_valid) begin
          k_mem[idx] <= s_data[W_K-1:0];
          if (idx == LAST_K) begin
            idx     <= '0;
            k_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        LOAD_X: if (s_valid) begin
          x_mem[col] <= s_data[W_X-1:0];
          col        <= (col == LAST_C) ? '0 : col + 1'b1;
        end
        COMPUTE: begin
          acc <= sum;
          idx <= (idx == LAST_K) ? '0 : idx + 1'b1;
          if (col == LAST_C) begin
            y_mem[row] <= conv(sum);
            col        <= '0;
            row        <= (row == LAST_R) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        SEND: if (m_ready) begin
          if (row == LAST_R) begin
            row  <= '0;
            done <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream_core.sv
// Bench for mvm_stream_core: two instances (saturating and truncating) share
// one stimulus. A frame-level model in the negedge monitor collects the
// accepted bytes, computes Y with integer arithmetic and predicts every
// output cycle by cycle. Directed scenarios come first, then random traffic.
module tb_mvm_stream_core;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int RC = R * C;

  logic       clk = 1'b0;
  logic       rst, s_valid, m_ready, keep_k;
  logic [7:0] s_data;
  logic       s_ready, m_valid, busy, done;
  logic       s_ready_t, m_valid_t, busy_t, done_t;
  logic [7:0] m_data, m_data_t;

  always #5 clk = ~clk;

  mvm_stream_core #(.R(R), .C(C), .W_X(4), .W_K(4), .W_Y_OUT(8),
                    .SIGNED(1), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .keep_k(keep_k), .busy(busy), .done(done));

  mvm_stream_core #(.R(R), .C(C), .W_X(4), .W_K(4), .W_Y_OUT(8),
                    .SIGNED(1), .SATURATE(0)) dut_t (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready_t), .m_data(m_data_t), .m_valid(m_valid_t),
    .m_ready(m_ready), .keep_k(keep_k), .busy(busy_t), .done(done_t));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int elem(input logic [7:0] b);
    int v;
    v = int'(b[3:0]);
    if (v >= 8) v -= 16;
    return v;
  endfunction

  function automatic int sat8(input int y);
    if (y > 127)  return 8'h7F;
    if (y < -128) return 8'h80;
    return y & 255;
  endfunction

  function automatic int trunc8(input int y);
    return y & 255;
  endfunction

  int     kbuf [RC];
  int     xbuf [C];
  int     kcnt, xcnt;
  bit     started = 0, loading = 1, need_k = 1, have_k = 0;
  bit     done_exp = 0, after_rst = 0, exp_valid;
  longint cyc = 0, first_valid = 0;
  int     yq_s[$], yq_t[$];
  int     log_s[$], log_t[$];

  always @(negedge clk) begin
    cyc++;
    exp_valid = !loading && yq_s.size() > 0 && cyc >= first_valid;
    if (started) begin
      chk("s_ready", s_ready, loading);
      chk("s_ready_t", s_ready_t, loading);
      chk("busy", busy, !loading);
      chk("m_valid", m_valid, exp_valid);
      chk("m_valid_t", m_valid_t, exp_valid);
      chk("done", done, done_exp);
      chk("done_t", done_t, done_exp);
      if (exp_valid) begin
        chk("m_data", m_data, yq_s[0]);
        chk("m_data_t", m_data_t, yq_t[0]);
      end
      if (after_rst) chk("m_data_reset", m_data, 0);
    end
    done_exp  = 0;
    after_rst = 0;
    if (rst) begin
      started = 1; after_rst = 1;
      loading = 1; need_k = 1; have_k = 0;
      kcnt = 0; xcnt = 0;
      yq_s.delete(); yq_t.delete();
    end else if (started) begin
      if (loading && s_valid) begin
        if (need_k) begin
          kbuf[kcnt] = elem(s_data);
          kcnt++;
          if (kcnt == RC) begin need_k = 0; have_k = 1; kcnt = 0; end
        end else begin
          xbuf[xcnt] = elem(s_data);
          xcnt++;
          if (xcnt == C) begin
            for (int r = 0; r < R; r++) begin
              int y;
              y = 0;
              for (int c = 0; c < C; c++) y += kbuf[r*C + c] * xbuf[c];
              yq_s.push_back(sat8(y));
              yq_t.push_back(trunc8(y));
            end
            xcnt = 0; loading = 0;
            first_valid = cyc + RC + 1;
          end
        end
      end else if (exp_valid && m_ready) begin
        log_s.push_back(yq_s.pop_front());
        log_t.push_back(yq_t.pop_front());
        if (yq_s.size() == 0) begin
          done_exp = 1; loading = 1;
          need_k = !(keep_k && have_k);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  typedef logic [7:0] bytes6_t [6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit took;
    n = 0; took = 0;
    s_data = b; s_valid = 1'b1;
    while (!took && n < 100) begin
      @(negedge clk); took = s_ready;
      tick(); n++;
    end
    s_valid = 1'b0;
    if (!took) chk("send_timeout", 0, 1);
  endtask

  task automatic send_seq(input bytes6_t b, input int n);
    for (int i = 0; i < n; i++) send_byte(b[i]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 200);
    if (!done) chk("done_timeout", 0, 1);
    tick();
  endtask

  task automatic chk_logs(input string name, input int s0, input int s1,
                          input int t0, input int t1);
    chk({name, "_count"}, log_s.size(), 2);
    chk({name, "_y0"}, log_s.size() > 0 ? log_s[0] : -1, s0);
    chk({name, "_y1"}, log_s.size() > 1 ? log_s[1] : -1, s1);
    chk({name, "_t_y0"}, log_t.size() > 0 ? log_t[0] : -1, t0);
    chk({name, "_t_y1"}, log_t.size() > 1 ? log_t[1] : -1, t1);
    log_s.delete(); log_t.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; keep_k = 1'b0;

    // Pin the model's element and conversion rules to hand-worked values.
    chk("pin_elem_neg", elem(8'hF8), -8);
    chk("pin_elem_pos", elem(8'hA7), 7);
    chk("pin_sat_hi", sat8(128), 8'h7F);
    chk("pin_sat_neg", sat8(-112), 8'h90);
    chk("pin_sat_lo", sat8(-200), 8'h80);
    chk("pin_trunc", trunc8(128), 8'h80);

    repeat (2) tick();
    rst = 1'b0;

    // Defaults: K=1,2,3,4 X=5,6 -> 0x11, 0x27
    send_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 6);
    wait_done();
    chk_logs("basic", 8'h11, 8'h27, 8'h11, 8'h27);
    @(negedge clk); chk("basic_s_ready", s_ready, 1);
    tick();

    // Upper bits ignored; keep_k held high so K survives.
    keep_k = 1'b1;
    send_seq('{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6}, 6);
    wait_done();
    chk_logs("upper", 8'h11, 8'h27, 8'h11, 8'h27);

    // Weight hold: only X needed.
    send_seq('{8'h07, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    keep_k = 1'b0;
    @(negedge clk); chk("hold_s_ready", s_ready, 0);
    tick();
    wait_done();
    chk_logs("hold", 8'h09, 8'h19, 8'h09, 8'h19);

    // Back-pressure.
    m_ready = 1'b0;
    send_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 6);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 50);
    chk("bp_valid_rise", m_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", m_data, 8'h11);
      chk("bp_valid", m_valid, 1);
      chk("bp_s_ready", s_ready, 0);
      @(negedge clk);
    end
    tick();
    m_ready = 1'b1;
    wait_done();
    chk_logs("bp", 8'h11, 8'h27, 8'h11, 8'h27);

    // Signed saturation vs truncation.
    send_seq('{8'h08, 8'h08, 8'h07, 8'h07, 8'h08, 8'h08}, 6);
    wait_done();
    chk_logs("sat", 8'h7F, 8'h90, 8'h80, 8'h90);

    // Mid-frame reset with keep_k high: full K still required.
    keep_k = 1'b1;
    send_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00}, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk); chk("rst_s_ready", s_ready, 1);
    tick();
    send_seq('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 6);
    wait_done();
    chk_logs("midrst", 8'h11, 8'h27, 8'h11, 8'h27);

    // Random traffic; the monitor model checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      keep_k  = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mvm_stream_core.md
Name: mvm_stream_core

Overview:
- Parametrised matrix-vector multiply engine, Y = K·X, with K of R×C elements and X of C elements.
- Operands arrive as a byte stream (valid/ready); results leave as a word stream (valid/ready).
- Sits between the UART RX deserialiser and the TX serialiser in the MVM UART system. Replaces the fixed unsigned 2×2 core.
- New over the previous generation: signed/unsigned mode, saturating or truncating output, weight-hold (K reuse across frames) and back-pressure on both sides.

Parameters:
- R, 2, matrix rows / output vector length (≥1)
- C, 2, matrix columns / input vector length (≥1)
- W_X, 4, X element width (1..8)
- W_K, 4, K element width (1..8)
- W_Y_OUT, 8, output word width (1..16)
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
- SATURATE, 1, 1 = clamp result to W_Y_OUT range, 0 = keep low W_Y_OUT bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- s_data  in  8  input byte; element in low W_K or W_X bits, upper bits ignored
- s_valid  in  1  input byte valid
- s_ready  out  1  core accepts byte
- m_data  out  W_Y_OUT  output element Y[i]
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- keep_k  in  1  reuse stored K for next frame
- busy  out  1  high in COMPUTE or SEND
- done  out  1  one-cycle pulse after last output handshake

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: s_ready=1, m_valid=0, m_data=0, busy=0, done=0. State=LOAD_K, k_valid=0, all indices 0. K/X/Y storage not cleared.
- Handshakes:
  - Byte accepted on a clk edge where s_valid && s_ready.
  - Word accepted on an edge where m_valid && m_ready.
  - m_data and m_valid held stable until accepted.
- Frame order: R·C K bytes, row-major K[0][0], K[0][1] … K[R-1][C-1]; then C X bytes, X[0] … X[C-1].
- Element extraction: element = s_data[W-1:0]. Sign-extended if SIGNED=1, zero-extended otherwise.
- Accumulator width: W_ACC = W_X + W_K + clog2(C) + 1. It never overflows.
- LOAD_K:
  - s_ready=1; each accept stores the next K element.
  - After the R·C-th accept: k_valid←1, go to LOAD_X.
- LOAD_X:
  - s_ready=1; each accept stores the next X element.
  - After the C-th accept, go to COMPUTE.
- COMPUTE:
  - s_ready=0, busy=1.
  - One MAC per cycle, row-major, exactly R·C cycles.
  - acc cleared at the start of each row.
  - On the row's C-th MAC, (acc + product) is output-converted and written to Y[row].
- Output conversion:
  - SATURATE=1, SIGNED=1: clamp to [−2^(W_Y_OUT−1), 2^(W_Y_OUT−1)−1].
  - SATURATE=1, SIGNED=0: clamp to [0, 2^W_Y_OUT−1].
  - SATURATE=0: low W_Y_OUT bits.
- SEND:
  - m_valid=1, m_data=Y[i] for i=0..R−1, advancing on each accept.
  - First m_valid is high in the cycle R·C+1 clock edges after the edge accepting the last X byte.
- End of SEND (edge accepting Y[R−1]):
  - m_valid←0; done=1 in the next cycle.
  - keep_k is sampled on this same edge. If keep_k && k_valid, go to LOAD_X; else go to LOAD_K.
- s_ready is 0 throughout COMPUTE and SEND. Input bytes are never dropped; upstream stalls.
- Simultaneous s_valid and m_ready activity cannot conflict, because load and send phases are exclusive.
- keep_k only has effect when sampled at end of SEND; the level at other times is ignored.
- The first frame after reset always loads K, regardless of keep_k.
- rst asserted mid-frame: partial K/X are discarded, k_valid=0, return to LOAD_K on the next cycle.
- R=1 or C=1 are legal. The degenerate single-element paths must work.

Test Plan:
- Defaults. Send 01 02 03 04 05 06, m_ready=1, keep_k=0 → m_data 0x11 then 0x27. done pulses once. s_ready returns to 1.
- Signed saturation. K=8,8,7,7 (−8,−8,7,7), X=8,8 (−8,−8) → y0=128 saturates to 0x7F; y1=−112 → 0x90.
- Weight hold. After the first scenario, keep_k=1 at the last output handshake, then send only 07 01 → s_ready drops after 2 bytes; outputs 0x09, 0x19.
- Back-pressure. Hold m_ready=0 for 5 cycles when m_valid rises → m_data held at 0x11, m_valid held, s_ready=0. Then 0x11 and 0x27 are delivered in order.
- Mid-frame reset. Assert rst for 1 cycle after 5 bytes, with keep_k=1 → s_ready=1 and a full K is required. Then 01 02 03 04 05 06 → 0x11, 0x27.
- Upper bits and truncation. Send F1 F2 F3 F4 F5 F6 → same as the first scenario (0x11, 0x27). Repeat with SATURATE=0, K=8,8,7,7, X=8,8 → 0x80, 0x90.
